// File: rtl/fft_pingpong_ram.sv
// Two-bank ping-pong sample buffer for the FFT datapath: sequential fill, random-address frame readout.
// Define FFT_PINGPONG_BITREV_EN to bit-reverse rd_addr before lookup (radix-2 reorder on sequential reads).
module fft_pingpong_ram #(
  parameter int DW = 16,
  parameter int AW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          rd_release,
  output logic          frame_ready,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic [CW-1:0] frame_cnt
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    S_FILL,
    S_WAIT
  } state_t;

  logic [DW-1:0] mem [2*DEPTH];
  logic [AW-1:0] wr_ptr;
  logic          wbank;
  state_t        state;
  logic [AW-1:0] rd_addr_eff;

  logic wr_acc;
  logic last_wr;
  logic drop;

  assign wr_acc  = wr_en & wr_ready;
  assign last_wr = wr_acc & (&wr_ptr);
  assign drop    = wr_en & ~wr_ready;

`ifdef FFT_PINGPONG_BITREV_EN
  always_comb begin
    rd_addr_eff = '0;
    for (int i = 0; i < AW; i++) rd_addr_eff[i] = rd_addr[AW-1-i];
  end
`else
  assign rd_addr_eff = rd_addr;
`endif

  // NOTE: the sample array has no reset; a frame only becomes readable after every word is rewritten.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[{wbank, wr_ptr}] <= wr_data;
  end

  // NOTE: all state below uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      wbank       <= 1'b0;
      state       <= S_FILL;
      wr_ready    <= 1'b1;
      frame_ready <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      overflow    <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (last_wr) frame_cnt <= frame_cnt + 1'b1;

      unique case (state)
        S_FILL: begin
          if (last_wr) begin
            // A release landing on the last write frees the read bank, so swap with no gap.
            if (!frame_ready || rd_release) begin
              wbank       <= ~wbank;
              frame_ready <= 1'b1;
            end else begin
              state    <= S_WAIT;
              wr_ready <= 1'b0;
            end
          end else if (rd_release) begin
            frame_ready <= 1'b0;
          end
        end
        S_WAIT: begin
          if (rd_release) begin
            wbank       <= ~wbank;
            frame_ready <= 1'b1;
            state       <= S_FILL;
            wr_ready    <= 1'b1;
          end
        end
        default: state <= S_FILL;
      endcase

      // Reads use the pre-edge bank, so a read alongside release still sees the old frame.
      if (rd_en && frame_ready) begin
        rd_data  <= mem[{~wbank, rd_addr_eff}];
        rd_valid <= 1'b1;
      end else begin
        rd_valid <= 1'b0;
      end

      if (drop) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Scoreboard bench for fft_pingpong_ram: frame-level reference model, directed scenarios then random traffic.
module tb_fft_pingpong_ram;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int CW = 4;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_release = 1'b0;
  logic          frame_ready;
  logic          overflow;
  logic          ovf_clr = 1'b0;
  logic [CW-1:0] frame_cnt;

  always #5 clk = ~clk;

  fft_pingpong_ram #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_release(rd_release), .frame_ready(frame_ready),
    .overflow(overflow), .ovf_clr(ovf_clr), .frame_cnt(frame_cnt)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] exp_q[$];

  // Reference model: the frame being filled, the frame held for the reader, and a completed frame stuck behind it.
  logic [DW-1:0] m_fill[$];
  logic [DW-1:0] m_held[N];
  logic [DW-1:0] m_pend[N];
  bit            m_held_ok;
  bit            m_waiting;
  bit            m_ovf;
  int            m_frames;
  logic [DW-1:0] m_last_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int phys(input int a);
`ifdef FFT_PINGPONG_BITREV_EN
    int r = 0;
    for (int i = 0; i < AW; i++) if (a[i]) r |= 1 << (AW - 1 - i);
    return r;
`else
    return a;
`endif
  endfunction

  task automatic model_reset();
    m_fill.delete();
    m_held_ok = 0;
    m_waiting = 0;
    m_ovf     = 0;
    m_frames  = 0;
    m_last_rd = '0;
  endtask

  task automatic check_status();
    check("wr_ready", wr_ready, !m_waiting);
    check("frame_ready", frame_ready, m_held_ok);
    check("overflow", overflow, m_ovf);
    check("frame_cnt", frame_cnt, m_frames % (1 << CW));
    check("rd_data_hold", rd_data, m_last_rd);
  endtask

  task automatic step(input bit we, input logic [DW-1:0] wd, input bit re, input int ra,
                      input bit rel, input bit clr);
    bit drop;
    bit relv;
    bit complete;
    logic [DW-1:0] d;
    @(negedge clk);
    check_status();
    wr_en = we; wr_data = wd; rd_en = re; rd_addr = AW'(ra);
    rd_release = rel; ovf_clr = clr;

    drop = we && m_waiting;
    relv = rel && m_held_ok;
    if (re && m_held_ok) begin
      d = m_held[phys(ra)];
      exp_q.push_back(d);
      m_last_rd = d;
    end
    if (m_waiting) begin
      if (rel) begin
        m_held    = m_pend;
        m_waiting = 0;
      end
    end else begin
      complete = 0;
      if (we) begin
        m_fill.push_back(wd);
        complete = (m_fill.size() == N);
      end
      if (complete) begin
        m_frames++;
        if (!m_held_ok || rel) begin
          for (int i = 0; i < N; i++) m_held[i] = m_fill[i];
          m_held_ok = 1;
        end else begin
          for (int i = 0; i < N; i++) m_pend[i] = m_fill[i];
          m_waiting = 1;
        end
        m_fill.delete();
      end else if (relv) begin
        m_held_ok = 0;
      end
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wr_en = 0; rd_en = 0; rd_release = 0; ovf_clr = 0;
    model_reset();
    exp_q.delete();
    @(negedge clk);
    check_status();
    check("rd_valid_reset", rd_valid, 0);
    rst = 1'b0;
  endtask

  task automatic write_frame(input logic [DW-1:0] base, input int count, input bit rel_last);
    for (int i = 0; i < count; i++)
      step(1, base + DW'(i), 0, 0, rel_last && (i == count - 1), 0);
  endtask

  task automatic read_all();
    for (int a = 0; a < N; a++) step(0, '0, 1, a, 0, 0);
  endtask

  // Monitor: every rd_valid pops one expected sample; a pending expectation without rd_valid is a miss.
  always @(posedge clk) begin
    #1;
    if (rd_valid) begin
      if (exp_q.size() == 0) check("rd_valid_spurious", rd_valid, 0);
      else check("rd_data", rd_data, exp_q.pop_front());
    end else if (exp_q.size() != 0) begin
      check("rd_valid", rd_valid, 1);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    do_reset();

    step(0, '0, 1, 3, 0, 0);
    step(0, '0, 1, 5, 0, 0);

    write_frame(16'h0001, N, 0);
    read_all();

    write_frame(16'h0101, N, 0);
    step(1, 16'hdead, 0, 0, 0, 0);
    step(0, '0, 1, 2, 1, 0);
    read_all();
    step(0, '0, 0, 0, 0, 1);

    write_frame(16'h0201, N, 1);
    read_all();

    write_frame(16'h0301, N, 0);
    step(1, 16'hbeef, 0, 0, 0, 1);
    step(0, '0, 0, 0, 0, 1);
    step(0, '0, 0, 0, 1, 0);
    read_all();

    write_frame(16'h0401, 5, 0);
    do_reset();
    write_frame(16'h0000, N, 0);
    read_all();

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(1499) == 0) do_reset();
      else step(($urandom & 3) != 0, DW'($urandom), $urandom_range(1),
                int'($urandom_range(N - 1)), $urandom_range(11) == 0,
                $urandom_range(15) == 0);
    end

    for (int c = 0; c < 3; c++) step(0, '0, 0, 0, 0, 0);
    check("rd_queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
